// File: rtl/fp32_div_norm_round.sv
// Post-divide stage of the FP32 divider.
// Takes the raw quotient fraction and the operand signs/exponents, then
// normalises, rounds (round-to-nearest-even) and packs an IEEE-754 single.
// Operands that are zero, inf or NaN are resolved upstream and take a bypass
// straight to the output state.
module fp32_div_norm_round #(
  parameter int Q_W  = 26,
  parameter int BIAS = 127
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_sign_a,
  input  logic           i_sign_b,
  input  logic [7:0]     i_exp_a,
  input  logic [7:0]     i_exp_b,
  input  logic [Q_W-1:0] i_fract_q,
  input  logic           i_rem_nz,
  input  logic           i_special,
  input  logic [31:0]    i_special_result,
  input  logic           i_ready,
  output logic [31:0]    o_result,
  output logic           o_valid,
  output logic           o_busy,
  output logic           o_overflow,
  output logic           o_underflow
);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ROUND, S_PACK, S_OUT} state_t;

  // Masks that select every quotient bit below the guard bit. With the integer
  // bit set the guard is q[Q_W-25]; otherwise it is q[Q_W-26]. At Q_W=26 the
  // second mask is empty, so only the remainder feeds the sticky bit.
  localparam logic [Q_W-1:0] STICKY_MASK_HI = {Q_W{1'b1}} >> 25;
  localparam logic [Q_W-1:0] STICKY_MASK_LO = {Q_W{1'b1}} >> 26;

  state_t                 state_q;
  logic                   sign_q;
  logic signed [9:0]      exp_q;
  logic [Q_W-1:0]         quo_q;
  logic                   rem_q;
  logic [23:0]            man_q;
  logic                   grd_q;
  logic                   stk_q;

  logic signed [9:0]      exp_d;
  logic                   inc_d;
  logic [24:0]            man_rnd_d;

  // Unbiased-difference exponent at capture time and the RNE increment.
  always_comb begin
    exp_d     = $signed({2'b00, i_exp_a}) - $signed({2'b00, i_exp_b})
              + $signed(10'(BIAS));
    inc_d     = grd_q & (stk_q | man_q[0]);
    man_rnd_d = {1'b0, man_q} + {24'd0, inc_d};
  end

  assign o_busy = (state_q != S_IDLE);

  // Sequencer and datapath: capture, normalise, round, pack, then hold the
  // result until the consumer accepts it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      quo_q       <= '0;
      rem_q       <= 1'b0;
      man_q       <= '0;
      grd_q       <= 1'b0;
      stk_q       <= 1'b0;
      o_result    <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            sign_q <= i_sign_a ^ i_sign_b;
            exp_q  <= exp_d;
            quo_q  <= i_fract_q;
            rem_q  <= i_rem_nz;
            if (i_special) begin
              o_result    <= i_special_result;
              o_valid     <= 1'b1;
              o_overflow  <= 1'b0;
              o_underflow <= 1'b0;
              state_q     <= S_OUT;
            end else begin
              state_q <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (quo_q[Q_W-1]) begin
            man_q <= quo_q[Q_W-1 -: 24];
            grd_q <= quo_q[Q_W-25];
            stk_q <= (|(quo_q & STICKY_MASK_HI)) | rem_q;
          end else begin
            // Quotient below 1.0: shift left one place, borrow from exponent.
            man_q <= quo_q[Q_W-2 -: 24];
            grd_q <= quo_q[Q_W-26];
            stk_q <= (|(quo_q & STICKY_MASK_LO)) | rem_q;
            exp_q <= exp_q - 10'sd1;
          end
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          // A carry out of the mantissa means it rounded up to 2.0.
          if (man_rnd_d[24]) begin
            man_q <= man_rnd_d[24:1];
            exp_q <= exp_q + 10'sd1;
          end else begin
            man_q <= man_rnd_d[23:0];
          end
          state_q <= S_PACK;
        end
        S_PACK: begin
          if (exp_q >= 10'sd255) begin
            o_result   <= {sign_q, 8'hFF, 23'h0};
            o_overflow <= 1'b1;
          end else if (exp_q <= 10'sd0) begin
            o_result    <= {sign_q, 31'h0};
            o_underflow <= 1'b1;
          end else begin
            o_result <= {sign_q, exp_q[7:0], man_q[22:0]};
          end
          o_valid <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) begin
            o_valid     <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_norm_round.sv
// Bench for fp32_div_norm_round: directed cases followed by a randomized
// sweep. Each sweep result is checked against a value-level rounding model.
module tb_fp32_div_norm_round;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_sign_a, i_sign_b, i_rem_nz, i_special, i_ready;
  logic [7:0]  i_exp_a, i_exp_b;
  logic [25:0] i_fract_q;
  logic [31:0] i_special_result, o_result;
  logic        o_valid, o_busy, o_overflow, o_underflow;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fp32_div_norm_round #(.Q_W(26), .BIAS(127)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
    .i_exp_a(i_exp_a), .i_exp_b(i_exp_b),
    .i_fract_q(i_fract_q), .i_rem_nz(i_rem_nz),
    .i_special(i_special), .i_special_result(i_special_result),
    .i_ready(i_ready), .o_result(o_result), .o_valid(o_valid),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Value-level model. The quotient is an integer scaled by 2^25. Keep the top
  // 24 significant bits, then round by comparing the discarded remainder with
  // one half ulp; the divider remainder breaks exact ties upward.
  function automatic void model(input bit sa, input bit sb, input int ea, input int eb,
                                input int q, input bit rnz,
                                output logic [31:0] res, output bit ov, output bit un);
    int sh, m, rem, half, e;
    bit up, s;
    sh   = (q >= (1 << 25)) ? 2 : 1;
    m    = q >> sh;
    rem  = q % (1 << sh);
    half = 1 << (sh - 1);
    e    = ea - eb + 127 - ((sh == 2) ? 0 : 1);
    if (rem > half)       up = 1'b1;
    else if (rem < half)  up = 1'b0;
    else                  up = rnz || (m % 2 == 1);
    m = m + (up ? 1 : 0);
    if (m == (1 << 24)) begin m = m / 2; e = e + 1; end
    s  = sa ^ sb;
    ov = 1'b0; un = 1'b0;
    if (e >= 255) begin res = {s, 8'hFF, 23'h0}; ov = 1'b1; end
    else if (e <= 0) begin res = {s, 31'h0}; un = 1'b1; end
    else res = {s, e[7:0], m[22:0]};
  endfunction

  // One transaction. glitch=1 keeps i_start asserted with different operands
  // during NORM and pulses a bypass request while the result waits in OUT;
  // neither may disturb the result.
  task automatic run_op(input string tag, input bit sa, input bit sb,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input logic [25:0] q, input bit rnz, input bit spec,
                        input logic [31:0] sres, input int rdly, input bit glitch,
                        input logic [31:0] want_res, input bit use_want);
    logic [31:0] er;
    bit eo, eu;
    int lat;
    if (spec) begin er = sres; eo = 1'b0; eu = 1'b0; end
    else model(sa, sb, int'(ea), int'(eb), int'(q), rnz, er, eo, eu);
    if (use_want) chk({tag, " model"}, er, want_res);
    @(negedge clk);
    i_sign_a = sa; i_sign_b = sb; i_exp_a = ea; i_exp_b = eb; i_fract_q = q;
    i_rem_nz = rnz; i_special = spec; i_special_result = sres;
    i_start = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    if (glitch && !spec) begin
      i_exp_a = ~ea; i_fract_q = ~q; i_sign_a = ~sa; i_special = 1'b1;
      @(posedge clk); #1;
      lat = 1;
    end
    i_start = 1'b0; i_special = 1'b0;
    while (o_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), spec ? 32'd0 : 32'd3);
    chk({tag, " result"}, o_result, er);
    chk({tag, " ovf"}, {31'd0, o_overflow}, {31'd0, eo});
    chk({tag, " unf"}, {31'd0, o_underflow}, {31'd0, eu});
    chk({tag, " busy"}, {31'd0, o_busy}, 32'd1);
    for (int k = 0; k < rdly; k++) begin
      if (glitch) begin
        i_start = 1'b1; i_special = 1'b1; i_special_result = 32'h1234_5678;
      end
      @(posedge clk); #1;
      i_start = 1'b0; i_special = 1'b0;
      chk({tag, " hold valid"}, {31'd0, o_valid}, 32'd1);
      chk({tag, " hold result"}, o_result, er);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk({tag, " post valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, " post busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, " post flags"}, {30'd0, o_overflow, o_underflow}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " result"}, o_result, 32'd0);
    chk({tag, " ctl"}, {28'd0, o_valid, o_busy, o_overflow, o_underflow}, 32'd0);
  endtask

  initial begin
    logic [25:0] rq;
    logic [7:0]  rea, reb;
    i_rst = 1'b1; i_start = 1'b0; i_sign_a = 1'b0; i_sign_b = 1'b0;
    i_exp_a = 8'd127; i_exp_b = 8'd127; i_fract_q = '0; i_rem_nz = 1'b0;
    i_special = 1'b0; i_special_result = '0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    i_rst = 1'b0;

    run_op("1.5/1.0", 0, 0, 8'd127, 8'd127, 26'h300_0000, 0, 0, 0, 0, 0, 32'h3FC0_0000, 1);
    run_op("1.0/1.5", 0, 0, 8'd127, 8'd127, 26'h155_5555, 1, 0, 0, 0, 0, 32'h3F2A_AAAB, 1);
    run_op("carry",   0, 0, 8'd127, 8'd127, 26'h3FF_FFFF, 0, 0, 0, 0, 0, 32'h4000_0000, 1);
    run_op("ovf",     0, 0, 8'd254, 8'd1,   26'h200_0000, 0, 0, 0, 0, 0, 32'h7F80_0000, 1);
    run_op("unf",     1, 0, 8'd1,   8'd254, 26'h200_0000, 0, 0, 0, 0, 0, 32'h8000_0000, 1);
    run_op("hshake",  1, 1, 8'd130, 8'd120, 26'h2AB_CDEF, 1, 0, 0, 3, 1, 32'h0, 0);
    run_op("bypass",  0, 0, 8'd0,   8'd0,   26'h0,        0, 1, 32'h7FC0_0000, 1, 0, 32'h0, 0);
    // Ties broken to even when the remainder is zero.
    run_op("tie-even", 0, 0, 8'd127, 8'd127, 26'h100_0001, 0, 0, 0, 0, 0, 32'h3F00_0000, 1);
    run_op("tie-odd",  0, 0, 8'd127, 8'd127, 26'h200_0006, 0, 0, 0, 0, 0, 32'h3F80_0002, 1);

    // Reset while in ROUND: the operation is dropped.
    @(negedge clk);
    i_exp_a = 8'd140; i_exp_b = 8'd100; i_fract_q = 26'h2C0_0000; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk_reset_state("rst-round");

    // Reset while the result waits in OUT: the pending result is lost.
    @(negedge clk);
    i_start = 1'b1; i_special = 1'b1; i_special_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    i_start = 1'b0; i_special = 1'b0;
    chk("rst-out pre", {31'd0, o_valid}, 32'd1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk_reset_state("rst-out");

    for (int n = 0; n < 200; n++) begin
      rq  = 26'($urandom_range(32'h3FF_FFFF, 32'h100_0001));
      rea = 8'($urandom_range(254, 1));
      reb = 8'($urandom_range(254, 1));
      if (n % 3 == 0) begin
        rea = 8'($urandom_range(160, 100));
        reb = 8'($urandom_range(160, 100));
      end
      run_op($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), rea, reb, rq,
             1'($urandom), 0, 0, int'($urandom_range(2)), 0, 32'h0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
